// File: rtl/present_slayer_serial.sv
// Nibble-serial PRESENT substitution layer driving one shared external 4-bit s-box.
// Optional pLayer on out_data is enabled by defining PRESENT_SLAYER_PLAYER_EN.
module present_slayer_serial #(
   parameter int unsigned NIBBLES = 16
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   in_valid,
   output logic                   in_ready,
   input  logic [4*NIBBLES-1:0]   in_data,
   output logic [3:0]             sbox_idat,
   input  logic [3:0]             sbox_odat,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic [4*NIBBLES-1:0]   out_data,
   output logic                   busy
);

   localparam int unsigned W        = 4 * NIBBLES;
   localparam int unsigned CNT_W    = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(NIBBLES - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_e;

   state_e           state_q, state_d;
   logic [W-1:0]     shift_q, shift_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             in_ready_q, in_ready_d;
   logic             out_valid_q, out_valid_d;
   logic             busy_q, busy_d;
   logic [3:0]       sbox_idat_q, sbox_idat_d;

   // State register and registered handshake/s-box outputs
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         shift_q     <= '0;
         cnt_q       <= '0;
         in_ready_q  <= 1'b1;
         out_valid_q <= 1'b0;
         busy_q      <= 1'b0;
         sbox_idat_q <= 4'h0;
      end else begin
         state_q     <= state_d;
         shift_q     <= shift_d;
         cnt_q       <= cnt_d;
         in_ready_q  <= in_ready_d;
         out_valid_q <= out_valid_d;
         busy_q      <= busy_d;
         sbox_idat_q <= sbox_idat_d;
      end
   end

   // Next-state logic; outputs are decoded from the next state so they register cleanly
   always_comb begin
      state_d = state_q;
      shift_d = shift_q;
      cnt_d   = cnt_q;

      case (state_q)
         IDLE: begin
            if (in_valid) begin
               shift_d = in_data;
               cnt_d   = '0;
               state_d = RUN;
            end
         end
         RUN: begin
            // Substituted nibble enters at the top; after NIBBLES shifts it lands back in place
            shift_d = {sbox_odat, shift_q[W-1:4]};
            if (cnt_q == CNT_LAST) begin
               state_d = DONE;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         DONE: begin
            if (out_ready) begin
               state_d = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      in_ready_d  = (state_d == IDLE);
      out_valid_d = (state_d == DONE);
      busy_d      = (state_d != IDLE);
      sbox_idat_d = (state_d == RUN) ? shift_d[3:0] : 4'h0;
   end

   assign in_ready  = in_ready_q;
   assign out_valid = out_valid_q;
   assign busy      = busy_q;
   assign sbox_idat = sbox_idat_q;

`ifdef PRESENT_SLAYER_PLAYER_EN
   if (NIBBLES != 16) begin : g_bad_nibbles
      $error("present_slayer_serial: pLayer requires NIBBLES == 16");
   end

   // pLayer: bit i -> (16*i) mod 63, bit 63 fixed
   for (genvar i = 0; i < 63; i++) begin : g_player
      assign out_data[(16 * i) % 63] = shift_q[i];
   end
   assign out_data[W-1] = shift_q[W-1];
`else
   assign out_data = shift_q;
`endif

endmodule
